// File: rtl/alu_pkg.sv
// Shared types and constants for the subtractor writeback/flag stage.
package alu_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned WB_TAG_W = 3;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef struct packed {
        logic [WB_TAG_W-1:0] tag;
        logic [DATA_W-1:0]   data;
        logic [3:0]          flags;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy output; head data holds its last value once drained.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [WIDTH-1:0] hold_q;
    logic             pop;

    assign pop_valid = (level_q != '0);
    assign pop       = pop_valid && pop_ready;
    // hold_q keeps the last popped entry visible while empty (zero after reset)
    assign pop_data  = pop_valid ? mem[rd_ptr_q] : hold_q;
    assign level     = level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                hold_q   <= mem[rd_ptr_q];
            end
            level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        push |-> (level_q < LVL_W'(DEPTH)));

endmodule

// File: rtl/alu_sub_wb.sv
// Writeback/flag stage behind a registered 16-bit subtractor: issues operands,
// derives Z/N/C/V from the registered difference and queues results for writeback.
module alu_sub_wb
    import alu_pkg::*;
#(
    parameter int unsigned TAG_W = 3,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [15:0]       sub_a,
    output logic [15:0]       sub_b,
    input  logic [15:0]       sub_diff,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        out_flags,
    output logic [LVL_W-1:0]  level
);

    if (TAG_W != WB_TAG_W) begin : g_tag_w_check
        $error("alu_sub_wb: TAG_W must equal alu_pkg::WB_TAG_W");
    end

    logic             pipe_valid_q;
    logic [TAG_W-1:0] tag_q;
    logic             a15_q, b15_q, borrow_q;
    logic             accept;
    wb_entry_t        push_entry, head_entry;

    assign sub_a = in_a;
    assign sub_b = in_b;

    // Conservative credit: the in-flight op holds a slot; a same-cycle pop frees nothing.
    assign in_ready = ({1'b0, level} + {{LVL_W{1'b0}}, pipe_valid_q}) < (LVL_W + 1)'(DEPTH);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_q <= 1'b0;
            tag_q        <= '0;
            a15_q        <= 1'b0;
            b15_q        <= 1'b0;
            borrow_q     <= 1'b0;
        end else begin
            pipe_valid_q <= accept;
            if (accept) begin
                tag_q    <= in_tag;
                a15_q    <= in_a[DATA_W-1];
                b15_q    <= in_b[DATA_W-1];
                borrow_q <= (in_a < in_b);
            end
        end
    end

    always_comb begin
        push_entry              = '0;
        push_entry.tag          = tag_q;
        push_entry.data         = sub_diff;
        push_entry.flags[FLAG_Z] = (sub_diff == '0);
        push_entry.flags[FLAG_N] = sub_diff[DATA_W-1];
        push_entry.flags[FLAG_C] = borrow_q;
        push_entry.flags[FLAG_V] = (a15_q != b15_q) && (sub_diff[DATA_W-1] != a15_q);
    end

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid_q),
        .push_data (push_entry),
        .pop_ready (out_ready),
        .pop_valid (out_valid),
        .pop_data  (head_entry),
        .level     (level)
    );

    assign out_data  = head_entry.data;
    assign out_tag   = head_entry.tag;
    assign out_flags = head_entry.flags;

endmodule
